// File: rtl/lzd_norm_seq_if.sv
// Operand/result handshake bundle for the leading-zero normaliser.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand and result channels.
interface lzd_norm_seq_if #(
    parameter int WORDS = 2
);
    localparam int DATA_W = 32 * WORDS;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_norm;
    logic [CNT_W-1:0]  out_lzc;
    logic              out_zero;

    // Source of operands / sink of results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_norm, out_lzc, out_zero
    );

    // The normaliser itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_norm, out_lzc, out_zero
    );
endinterface

// File: rtl/lzd_norm_seq.sv
// Multi-cycle leading-zero count and left-normalise using one shared 32-bit LZD.
// Latency: k+2 edges (k = index of first non-zero word from MSW), WORDS+1 for zero.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.

// 32-bit leading-zero detector; returns 32 for an all-zero word.
module lzd_32 (
    input  logic [31:0] word_i,
    output logic [5:0]  cnt_o
);
    // Lowest-to-highest scan so the highest set bit wins the last assignment.
    always_comb begin
        cnt_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (word_i[i]) cnt_o = 6'(31 - i);
        end
    end
endmodule

module lzd_norm_seq #(
    parameter int  WORDS  = 2,
    localparam int DATA_W = 32 * WORDS,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    lzd_norm_seq_if.slave     bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    localparam logic [1:0] IDX_LAST = 2'(WORDS - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_norm_q, out_norm_d;
    logic [CNT_W-1:0]  out_lzc_q, out_lzc_d;
    logic              out_zero_q, out_zero_d;

    logic [31:0]       lzd_in;
    logic [5:0]        lzd_cnt;

    // Present the word at position idx counted from the MSW to the shared LZD.
    always_comb begin
        lzd_in = op_q[DATA_W-1 -: 32];
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == 2'(WORDS - 1 - w)) lzd_in = op_q[w*32 +: 32];
        end
    end

    lzd_32 u_lzd_32 (
        .word_i (lzd_in),
        .cnt_o  (lzd_cnt)
    );

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_norm_d  = out_norm_q;
        out_lzc_d   = out_lzc_q;
        out_zero_d  = out_zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.in_data;
                    idx_d   = 2'd0;
                    acc_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // A zero word only continues the scan if a lower word remains.
                if (lzd_cnt == 6'd32 && idx_q < IDX_LAST) begin
                    acc_d = acc_q + CNT_W'(32);
                    idx_d = idx_q + 2'd1;
                end else begin
                    acc_d   = acc_q + CNT_W'(lzd_cnt);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A shift of DATA_W clears the operand, which is the zero result.
                out_valid_d = 1'b1;
                out_lzc_d   = acc_q;
                out_zero_d  = (acc_q == CNT_W'(DATA_W));
                out_norm_d  = op_q << acc_q;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            op_q        <= '0;
            idx_q       <= 2'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_norm_q  <= '0;
            out_lzc_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_norm_q  <= out_norm_d;
            out_lzc_q   <= out_lzc_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_norm  = out_norm_q;
    assign bus.out_lzc   = out_lzc_q;
    assign bus.out_zero  = out_zero_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_lzd_norm_seq.sv
// Randomised and directed check of lzd_norm_seq with a queue-based scoreboard.
// Latency: checked per operand against the word-position rule.
// Backpressure: out_ready is held low, toggled randomly and held high.
module tb_lzd_norm_seq;
    localparam int WORDS  = 2;
    localparam int DATA_W = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;

    lzd_norm_seq_if #(.WORDS(WORDS)) bus ();

    lzd_norm_seq #(.WORDS(WORDS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] norm;
        int          lzc;
        bit          zero;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   rand_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: count zeros from the MSB, shift by that many, latency by word position.
    function automatic exp_t model(input logic [63:0] v, input int acc_cyc);
        exp_t e;
        int   z = 0;
        while (z < DATA_W && !v[DATA_W-1-z]) z++;
        e.lzc     = z;
        e.zero    = (z == DATA_W);
        e.norm    = e.zero ? 64'd0 : (v << z);
        e.lat     = e.zero ? (WORDS + 1) : (z / 32 + 2);
        e.acc_cyc = acc_cyc;
        return e;
    endfunction

    task automatic send(input logic [63:0] d);
        int w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        sb.push_back(model(d, cyc + 1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Monitor: latency on each rising out_valid, result contents on each handshake.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (sb.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
                else chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                chk("out_norm", bus.out_norm, sb[0].norm);
                chk("out_lzc", 64'(bus.out_lzc), 64'(sb[0].lzc));
                chk("out_zero", 64'(bus.out_zero), 64'(sb[0].zero));
                void'(sb.pop_front());
            end
            prev_v = bus.out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [63:0] h_norm;
        logic [6:0]  h_lzc;
        logic        h_zero;
        int          w;
        bit          seen;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_lzc", 64'(bus.out_lzc), 64'd0);
        chk("rst_out_norm", bus.out_norm, 64'd0);

        send(64'h8000_0000_0000_0000); drain();
        send(64'h0000_0001_0000_0000); drain();
        send(64'h0000_0000_0000_0003); drain();
        send(64'h0000_0000_0000_0000); drain();

        // Hold the result under backpressure.
        bus.out_ready = 1'b0;
        send(64'h0000_0000_0000_0000);
        w = 0;
        while (!bus.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        h_norm = bus.out_norm;
        h_lzc  = bus.out_lzc;
        h_zero = bus.out_zero;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(bus.out_valid), 64'd1);
            chk("bp_norm_hold", bus.out_norm, h_norm);
            chk("bp_lzc_hold", 64'(bus.out_lzc), 64'(h_lzc));
            chk("bp_zero_hold", 64'(bus.out_zero), 64'(h_zero));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        send(64'h0000_0000_FFFF_FFFF); drain();

        // Reset in the middle of scanning an all-zero operand.
        send(64'h0000_0000_0000_0000);
        @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_out_lzc", 64'(bus.out_lzc), 64'd0);
        chk("mrst_out_norm", bus.out_norm, 64'd0);
        chk("mrst_out_zero", 64'(bus.out_zero), 64'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mrst_no_output", 64'(seen), 64'd0);
        send(64'h0000_8000_0000_0000); drain();

        // Random operands with a random count of leading zeros and random backpressure.
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] r;
            int          sh;
            r  = {$urandom, $urandom};
            sh = $urandom_range(0, 64);
            r  = (sh == 64) ? 64'd0 : (r >> sh);
            send(r);
        end
        @(posedge clk);
        rand_en = 1'b0;
        #2;
        bus.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
